// File: rtl/mono_rom_scaler_if.sv
// Video/ROM bus between the display timing side and mono_rom_scaler.
// Build option: MONO_SCALER_INVERT_EN adds the invert input.
interface mono_rom_scaler_if #(
  parameter int CORDW = 16,
  parameter int ADDRW = 15
);
  logic                    frame;
  logic signed [CORDW-1:0] sx;
  logic signed [CORDW-1:0] sy;
  logic                    de;
`ifdef MONO_SCALER_INVERT_EN
  logic                    invert;
`endif
  logic [ADDRW-1:0]        rom_addr;
  logic                    rom_data;
  logic [11:0]             pix_colr;
  logic                    pix_de;

`ifdef MONO_SCALER_INVERT_EN
  modport master (
    output frame, sx, sy, de, invert, rom_data,
    input  rom_addr, pix_colr, pix_de
  );

  modport slave (
    input  frame, sx, sy, de, invert, rom_data,
    output rom_addr, pix_colr, pix_de
  );
`else
  modport master (
    output frame, sx, sy, de, rom_data,
    input  rom_addr, pix_colr, pix_de
  );

  modport slave (
    input  frame, sx, sy, de, rom_data,
    output rom_addr, pix_colr, pix_de
  );
`endif
endinterface

// File: rtl/mono_rom_scaler.sv
// Reads a 1-bit image ROM for the display, replicating each source pixel SCALE x SCALE.
// Build option: MONO_SCALER_INVERT_EN adds an invert input XORed with the ROM bit.
module mono_rom_scaler #(
  parameter int          IMG_W = 160,
  parameter int          IMG_H = 120,
  parameter int          SCALE = 4,
  parameter int          X_OFF = 0,
  parameter int          Y_OFF = 0,
  parameter int          CORDW = 16,
  parameter logic [11:0] FG    = 12'hFFF,
  parameter logic [11:0] BG    = 12'h000
) (
  input logic              clk,
  input logic              rst,
  mono_rom_scaler_if.slave bus
);
  localparam int ADDRW = $clog2(IMG_W * IMG_H);
  localparam int CNTW  = (SCALE > 1) ? $clog2(SCALE) : 1;

  localparam logic signed [CORDW-1:0] X_LO   = CORDW'(X_OFF);
  localparam logic signed [CORDW-1:0] X_HI   = CORDW'(X_OFF + IMG_W * SCALE);
  localparam logic signed [CORDW-1:0] X_LAST = CORDW'(X_OFF + IMG_W * SCALE - 1);
  localparam logic signed [CORDW-1:0] Y_LO   = CORDW'(Y_OFF);
  localparam logic signed [CORDW-1:0] Y_HI   = CORDW'(Y_OFF + IMG_H * SCALE);

  localparam logic [ADDRW-1:0] ROW_STEP  = ADDRW'(IMG_W);
  localparam logic [ADDRW-1:0] LAST_BASE = ADDRW'(IMG_W * (IMG_H - 1));
  localparam logic [CNTW-1:0]  CNT_MAX   = CNTW'(SCALE - 1);

  logic [ADDRW-1:0] addr_q, addr_d;
  logic [ADDRW-1:0] base_q, base_d;
  logic [CNTW-1:0]  cnt_x_q, cnt_x_d;
  logic [CNTW-1:0]  cnt_y_q, cnt_y_d;

  logic             win_d1_q, de_d1_q;
  logic [11:0]      pix_colr_q, pix_colr_d;
  logic             pix_de_q;

  logic             win, last_x, bit_on;

  assign win = bus.de
            && (bus.sx >= X_LO) && (bus.sx < X_HI)
            && (bus.sy >= Y_LO) && (bus.sy < Y_HI);
  assign last_x = (bus.sx == X_LAST);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    addr_d  = addr_q;
    base_d  = base_q;
    cnt_x_d = cnt_x_q;
    cnt_y_d = cnt_y_q;
    if (bus.frame) begin
      addr_d  = '0;
      base_d  = '0;
      cnt_x_d = '0;
      cnt_y_d = '0;
    end else if (win) begin
      if (last_x) begin
        cnt_x_d = '0;
        if (cnt_y_q == CNT_MAX) begin
          cnt_y_d = '0;
          // Wrapping after the last source row keeps the next frame aligned without a frame pulse.
          if (base_q == LAST_BASE) begin
            addr_d = '0;
            base_d = '0;
          end else begin
            base_d = base_q + ROW_STEP;
            addr_d = base_q + ROW_STEP;
          end
        end else begin
          cnt_y_d = cnt_y_q + 1'b1;
          addr_d  = base_q;
        end
      end else if (cnt_x_q == CNT_MAX) begin
        cnt_x_d = '0;
        addr_d  = addr_q + 1'b1;
      end else begin
        cnt_x_d = cnt_x_q + 1'b1;
      end
    end
  end

`ifdef MONO_SCALER_INVERT_EN
  logic inv_d1_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) inv_d1_q <= 1'b0;
    else     inv_d1_q <= bus.invert;
  end

  assign bit_on = bus.rom_data ^ inv_d1_q;
`else
  assign bit_on = bus.rom_data;
`endif

  // rom_data arrives one cycle after rom_addr, so it meets the stage-1 window flag here.
  always_comb begin
    pix_colr_d = BG;
    if (win_d1_q && bit_on) pix_colr_d = FG;
  end

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q     <= '0;
      base_q     <= '0;
      cnt_x_q    <= '0;
      cnt_y_q    <= '0;
      win_d1_q   <= 1'b0;
      de_d1_q    <= 1'b0;
      pix_colr_q <= '0;
      pix_de_q   <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      base_q     <= base_d;
      cnt_x_q    <= cnt_x_d;
      cnt_y_q    <= cnt_y_d;
      win_d1_q   <= win;
      de_d1_q    <= bus.de;
      pix_colr_q <= pix_colr_d;
      pix_de_q   <= de_d1_q;
    end
  end

  assign bus.rom_addr = addr_q;
  assign bus.pix_colr = pix_colr_q;
  assign bus.pix_de   = pix_de_q;
endmodule

// File: tb/tb_mono_rom_scaler.sv
// Directed bench for mono_rom_scaler: four parameterisations share one stimulus stream.
// Build option: MONO_SCALER_INVERT_EN enables the invert checks.
module tb_mono_rom_scaler;
  localparam logic [11:0] FG = 12'hFFF;
  localparam logic [11:0] BG = 12'h000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic               frame_r, de_r, inv_r;
  logic signed [15:0] sx_r, sy_r;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] row_start [0:15];

  mono_rom_scaler_if #(.CORDW(16), .ADDRW(15)) if_main ();
  mono_rom_scaler_if #(.CORDW(16), .ADDRW(15)) if_off ();
  mono_rom_scaler_if #(.CORDW(16), .ADDRW(15)) if_s1 ();
  mono_rom_scaler_if #(.CORDW(16), .ADDRW(5))  if_small ();

  assign if_main.frame  = frame_r;  assign if_main.sx  = sx_r;  assign if_main.sy  = sy_r;  assign if_main.de  = de_r;
  assign if_off.frame   = frame_r;  assign if_off.sx   = sx_r;  assign if_off.sy   = sy_r;  assign if_off.de   = de_r;
  assign if_s1.frame    = frame_r;  assign if_s1.sx    = sx_r;  assign if_s1.sy    = sy_r;  assign if_s1.de    = de_r;
  assign if_small.frame = frame_r;  assign if_small.sx = sx_r;  assign if_small.sy = sy_r;  assign if_small.de = de_r;
`ifdef MONO_SCALER_INVERT_EN
  assign if_main.invert  = inv_r;
  assign if_off.invert   = inv_r;
  assign if_s1.invert    = inv_r;
  assign if_small.invert = inv_r;
`endif

  // ROM model: each word's bit is the LSB of its address.
  always_ff @(posedge clk) begin
    if_main.rom_data  <= if_main.rom_addr[0];
    if_off.rom_data   <= if_off.rom_addr[0];
    if_s1.rom_data    <= if_s1.rom_addr[0];
    if_small.rom_data <= if_small.rom_addr[0];
  end

  mono_rom_scaler u_main (.clk(clk), .rst(rst), .bus(if_main.slave));
  mono_rom_scaler #(.X_OFF(80), .Y_OFF(60)) u_off (.clk(clk), .rst(rst), .bus(if_off.slave));
  mono_rom_scaler #(.SCALE(1)) u_s1 (.clk(clk), .rst(rst), .bus(if_s1.slave));
  mono_rom_scaler #(.IMG_W(8), .IMG_H(4), .SCALE(2)) u_small (.clk(clk), .rst(rst), .bus(if_small.slave));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_in(input bit f, input int x, input int y, input bit d);
    frame_r = f;
    sx_r    = 16'(x);
    sy_r    = 16'(y);
    de_r    = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic observe(input int sel, output logic [31:0] a, output logic [31:0] c, output logic d);
    a = '0; c = '0; d = 1'b0;
    case (sel)
      0: begin a = 32'(if_main.rom_addr);  c = 32'(if_main.pix_colr);  d = if_main.pix_de;  end
      1: begin a = 32'(if_off.rom_addr);   c = 32'(if_off.pix_colr);   d = if_off.pix_de;   end
      2: begin a = 32'(if_s1.rom_addr);    c = 32'(if_s1.pix_colr);    d = if_s1.pix_de;    end
      default: begin a = 32'(if_small.rom_addr); c = 32'(if_small.pix_colr); d = if_small.pix_de; end
    endcase
  endtask

  // Expected ROM address of a screen pixel, -1 when it lies outside that instance's window.
  function automatic int exp_addr(input int sel, input int x, input int y, input bit d);
    exp_addr = -1;
    if (d) begin
      case (sel)
        0: if (x >= 0 && x < 640 && y >= 0 && y < 480) exp_addr = (y / 4) * 160 + x / 4;
        1: if (x >= 80 && x < 720 && y >= 60 && y < 540) exp_addr = ((y - 60) / 4) * 160 + (x - 80) / 4;
        2: if (x >= 0 && x < 160 && y >= 0 && y < 120) exp_addr = y * 160 + x;
        default: if (x >= 0 && x < 16 && y >= 0 && y < 8) exp_addr = (y / 2) * 8 + x / 2;
      endcase
    end
  endfunction

  // Raster scan with two blanking cycles per row; checks address, colour and DE of every cycle.
  task automatic scan(input string tag, input int sel, input int y0, input int y1,
                      input int x0, input int x1, input bit pulse,
                      output logic [31:0] sig, output logic [31:0] last_a);
    int          errs;
    int          ea;
    logic [11:0] qc [$];
    bit          qd [$];
    logic [31:0] a, c;
    logic        d;
    bit          dv;
    errs   = 0;
    sig    = '0;
    last_a = '1;
    if (pulse) begin
      set_in(0, -1, -1, 0); tick();
      set_in(1, -1, -1, 0); tick();
    end
    for (int y = y0; y <= y1; y++) begin
      for (int x = x0; x <= x1 + 2; x++) begin
        dv = (x <= x1);
        set_in(0, x, y, dv);
        observe(sel, a, c, d);
        if (x == x0 && (y - y0) < 16) row_start[y - y0] = a;
        ea = exp_addr(sel, x, y, dv);
        if (ea >= 0) begin
          if (a !== 32'(ea)) errs++;
          last_a = a;
          qc.push_back((ea[0] ^ inv_r) ? FG : BG);
        end else begin
          qc.push_back(BG);
        end
        qd.push_back(dv);
        if (qc.size() > 2) begin
          if (c[11:0] !== qc.pop_front()) errs++;
          if (d !== qd.pop_front()) errs++;
        end
        sig = (sig * 33) ^ c ^ (a << 12) ^ {d, 31'b0};
        tick();
      end
    end
    check({tag, "_errs"}, 32'(errs), 0);
  endtask

  logic [31:0] sig_a, sig_b, sig_c, last_a, last_b, last_c;
  int          off_xs [10];

  initial begin
    rst   = 1'b1;
    inv_r = 1'b0;
    set_in(0, -1, -1, 0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_addr", 32'(if_main.rom_addr), 0);
    check("rst_colr", 32'(if_main.pix_colr), 0);
    check("rst_de",   32'(if_main.pix_de), 0);
    rst = 1'b0;
    tick();

    // Asynchronous reset in the middle of the window.
    set_in(1, -1, -1, 0); tick();
    for (int x = 0; x < 6; x++) begin
      set_in(0, x, 0, 1);
      tick();
    end
    set_in(0, 6, 0, 1);
    check("pre_rst_addr", 32'(if_main.rom_addr), 1);
    check("pre_rst_colr", 32'(if_main.pix_colr), 32'(FG));
    check("pre_rst_de",   32'(if_main.pix_de), 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_addr", 32'(if_main.rom_addr), 0);
    check("async_rst_colr", 32'(if_main.pix_colr), 0);
    check("async_rst_de",   32'(if_main.pix_de), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    set_in(0, 7, 0, 1);
    check("post_rst_first_addr", 32'(if_main.rom_addr), 0);
    tick();

    // Horizontal replication and two-cycle latency.
    set_in(0, -1, -1, 0); tick();
    set_in(1, -1, -1, 0); tick();
    for (int x = 0; x < 11; x++) begin
      set_in(0, x, 0, 1);
      if (x == 0 || x == 3 || x == 4 || x == 7)
        check($sformatf("scan_addr_x%0d", x), 32'(if_main.rom_addr), 32'(x / 4));
      if (x == 1)  check("lat_de_pulse",  32'(if_main.pix_de), 0);
      if (x == 2)  check("lat_de_x0",     32'(if_main.pix_de), 1);
      if (x == 2)  check("lat_colr_x0",   32'(if_main.pix_colr), 32'(BG));
      if (x == 6)  check("lat_colr_x4",   32'(if_main.pix_colr), 32'(FG));
      if (x == 10) check("lat_colr_x8",   32'(if_main.pix_colr), 32'(BG));
      tick();
    end

    // Vertical replication: nine full screen rows.
    scan("main_scan", 0, 0, 8, 0, 639, 1, sig_a, last_a);
    check("row0_start", row_start[0], 0);
    check("row3_start", row_start[3], 0);
    check("row4_start", row_start[4], 160);
    check("row8_start", row_start[8], 320);

    // Offset window: a pixel left of the window must not advance the scan.
    off_xs = '{80, 81, 82, 83, 84, 79, 85, 86, 87, 88};
    set_in(0, -1, -1, 0); tick();
    set_in(1, -1, -1, 0); tick();
    for (int i = 0; i < 10; i++) begin
      set_in(0, off_xs[i], 60, 1);
      if (i == 0) check("off_x80_addr", 32'(if_off.rom_addr), 0);
      if (i == 2) check("off_x80_colr", 32'(if_off.pix_colr), 32'(BG));
      if (i == 5) check("off_x79_addr", 32'(if_off.rom_addr), 1);
      if (i == 6) check("off_hold_addr", 32'(if_off.rom_addr), 1);
      if (i == 6) check("off_x84_colr", 32'(if_off.pix_colr), 32'(FG));
      if (i == 7) check("off_x79_colr", 32'(if_off.pix_colr), 32'(BG));
      if (i == 7) check("off_x79_de",   32'(if_off.pix_de), 1);
      if (i == 9) check("off_x88_addr", 32'(if_off.rom_addr), 2);
      tick();
    end
    scan("off_scan", 1, 60, 64, 76, 723, 1, sig_a, last_a);

    // Full-image wrap at SCALE=1, second frame without a frame pulse.
    scan("s1_frame1", 2, 0, 119, 0, 159, 1, sig_a, last_a);
    check("s1_final_addr", last_a, 19199);
    check("s1_wrap_addr", 32'(if_s1.rom_addr), 0);
    scan("s1_frame2", 2, 0, 119, 0, 159, 0, sig_b, last_b);
    check("s1_frame_sig", sig_b, sig_a);

    // Small image: frames with and without the pulse must match.
    scan("small_f1", 3, 0, 7, 0, 15, 1, sig_a, last_a);
    scan("small_f2", 3, 0, 7, 0, 15, 1, sig_b, last_b);
    scan("small_f3", 3, 0, 7, 0, 15, 0, sig_c, last_c);
    check("small_last_addr", last_a, 31);
    check("small_sig_pulse", sig_b, sig_a);
    check("small_sig_nopulse", sig_c, sig_a);

    // Frame pulse colliding with a window pixel at addr 37 (cnt_x=2).
    set_in(0, -1, -1, 0); tick();
    set_in(1, -1, -1, 0); tick();
    for (int x = 0; x < 150; x++) begin
      set_in(0, x, 0, 1);
      tick();
    end
    set_in(1, 150, 0, 1);
    check("coll_addr37", 32'(if_main.rom_addr), 37);
    tick();
    for (int x = 151; x < 156; x++) begin
      set_in(0, x, 0, 1);
      if (x == 151) check("coll_next_addr", 32'(if_main.rom_addr), 0);
      if (x == 154) check("coll_cnt_x_addr", 32'(if_main.rom_addr), 0);
      if (x == 155) check("coll_step_addr", 32'(if_main.rom_addr), 1);
      tick();
    end

`ifdef MONO_SCALER_INVERT_EN
    inv_r = 1'b1;
    set_in(0, -1, -1, 0); tick();
    set_in(1, -1, -1, 0); tick();
    for (int x = 0; x < 8; x++) begin
      set_in(0, x, 0, 1);
      if (x == 2) check("inv_colr_x0", 32'(if_main.pix_colr), 32'(FG));
      if (x == 6) check("inv_colr_x4", 32'(if_main.pix_colr), 32'(BG));
      tick();
    end
    set_in(0, 700, 0, 1); tick();
    set_in(0, -1, -1, 0); tick();
    check("inv_outside_bg", 32'(if_main.pix_colr), 32'(BG));
    scan("inv_scan", 0, 0, 1, 0, 639, 1, sig_a, last_a);
    inv_r = 1'b0;
`endif

    set_in(0, -1, -1, 0);
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
